// File: rtl/flit_sink.sv
// Packet framing checker: counts flits and HEAD..TAIL packets and flags the first framing error.
// Optional TOGGLE_CNT_EN adds a saturating idata bit-toggle counter on tog_cnt.
module flit_sink #(
  parameter int MAXLEN = 32,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [65:0]     idata,
  input  logic            ivalid,
  input  logic [1:0]      ivch,
  input  logic            clr,
  output logic            busy,
  output logic [CNTW-1:0] pkt_cnt,
  output logic [CNTW-1:0] flit_cnt,
  output logic [7:0]      last_len,
  output logic            err,
  output logic [2:0]      err_code,
  output logic [31:0]     tog_cnt
);
  localparam int LW = $clog2(MAXLEN + 1);

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_DATA = 2'b11;

  localparam logic [2:0] E_NO_HEAD  = 3'd1;
  localparam logic [2:0] E_DUP_HEAD = 3'd2;
  localparam logic [2:0] E_OVERLEN  = 3'd3;
  localparam logic [2:0] E_VCH      = 3'd4;

  typedef enum logic {IDLE, BODY} state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     len_q, len_d;
  logic [1:0]        vch_q, vch_d;
  logic [CNTW-1:0]   pkt_q, flit_q;
  logic [7:0]        last_len_q;
  logic              err_q;
  logic [2:0]        code_q;

  logic [1:0]        ftype;
  logic              acc, pkt_ev, err_ev;
  logic [2:0]        err_d;

  assign ftype = idata[65:64];
  assign acc   = ivalid && (ftype != 2'b00);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    vch_d   = vch_q;
    pkt_ev  = 1'b0;
    err_ev  = 1'b0;
    err_d   = 3'd0;
    if (acc) begin
      if (state_q == IDLE) begin
        if (ftype == T_HEAD) begin
          state_d = BODY;
          len_d   = '0;
          vch_d   = ivch;
        end else begin
          err_ev = 1'b1;
          err_d  = E_NO_HEAD;
        end
      end else if (ftype == T_HEAD) begin
        err_ev = 1'b1;
        err_d  = E_DUP_HEAD;
        len_d  = '0;
        vch_d  = ivch;
      end else if (ivch != vch_q) begin
        // A VC mismatch aborts the packet before the length is considered.
        err_ev  = 1'b1;
        err_d   = E_VCH;
        state_d = IDLE;
      end else if (ftype == T_TAIL) begin
        pkt_ev  = 1'b1;
        state_d = IDLE;
      end else if (ftype == T_DATA) begin
        if (len_q == LW'(MAXLEN)) begin
          err_ev  = 1'b1;
          err_d   = E_OVERLEN;
          state_d = IDLE;
        end else begin
          len_d = len_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q    <= IDLE;
      len_q      <= '0;
      vch_q      <= '0;
      pkt_q      <= '0;
      flit_q     <= '0;
      last_len_q <= '0;
      err_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      vch_q   <= vch_d;
      if (clr) begin
        pkt_q      <= '0;
        flit_q     <= '0;
        last_len_q <= '0;
        err_q      <= 1'b0;
        code_q     <= '0;
      end else begin
        if (acc && flit_q != '1)   flit_q <= flit_q + 1'b1;
        if (pkt_ev && pkt_q != '1) pkt_q  <= pkt_q + 1'b1;
        if (pkt_ev)                last_len_q <= 8'(len_q);
        if (err_ev && !err_q) begin
          err_q  <= 1'b1;
          code_q <= err_d;
        end
      end
    end
  end

  assign busy     = (state_q == BODY);
  assign pkt_cnt  = pkt_q;
  assign flit_cnt = flit_q;
  assign last_len = last_len_q;
  assign err      = err_q;
  assign err_code = code_q;

`ifdef TOGGLE_CNT_EN
  logic [65:0] idata_q;
  logic [31:0] tog_q;
  logic [6:0]  hd;
  logic [32:0] tsum;

  always_comb begin
    hd = '0;
    for (int i = 0; i < 66; i++) hd = hd + 7'(idata[i] ^ idata_q[i]);
  end

  assign tsum = {1'b0, tog_q} + 33'(hd);

  always_ff @(posedge clk) begin
    if (!rst_) begin
      idata_q <= '0;
      tog_q   <= '0;
    end else begin
      idata_q <= idata;
      if (clr) tog_q <= '0;
      else     tog_q <= tsum[32] ? '1 : tsum[31:0];
    end
  end

  assign tog_cnt = tog_q;
`else
  assign tog_cnt = '0;
`endif
endmodule

// File: tb/tb_flit_sink.sv
// Scoreboard bench for flit_sink: expectations are queued with the stimulus and
// drained once the registered outputs have settled after the sampling edge.
module tb_flit_sink;
  localparam logic [1:0] NONE = 2'b00, HEAD = 2'b01, TAIL = 2'b10, DATA = 2'b11;
  localparam int O_BUSY = 0, O_PKT = 1, O_FLIT = 2, O_LEN = 3, O_ERR = 4, O_CODE = 5, O_TOG = 6;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [65:0] idata = '0;
  logic        ivalid = 1'b0;
  logic [1:0]  ivch = '0;
  logic        clr = 1'b0;
  logic        busy, err;
  logic [15:0] pkt_cnt, flit_cnt;
  logic [7:0]  last_len;
  logic [2:0]  err_code;
  logic [31:0] tog_cnt;

  flit_sink #(.MAXLEN(32), .CNTW(16)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .clr(clr),
    .busy(busy), .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt), .last_len(last_len),
    .err(err), .err_code(err_code), .tog_cnt(tog_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_out(input int sel);
    case (sel)
      O_BUSY:  return 32'(busy);
      O_PKT:   return 32'(pkt_cnt);
      O_FLIT:  return 32'(flit_cnt);
      O_LEN:   return 32'(last_len);
      O_ERR:   return 32'(err);
      O_CODE:  return 32'(err_code);
      default: return tog_cnt;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, get_out(e.sel), e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flit(input logic [1:0] t, input logic [1:0] vc);
    idata  = {t, 32'($urandom()), 32'($urandom())};
    ivalid = 1'b1;
    ivch   = vc;
    step();
    ivalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idata  = {2'($urandom()), 32'($urandom()), 32'($urandom())};
      ivalid = 1'($urandom());
      clr    = 1'($urandom());
      step();
    end
    rst_ = 1'b1; idata = '0; ivalid = 1'b0; clr = 1'b0; ivch = '0;
  endtask

  initial begin
    // Reset: every output cleared.
    do_reset();
    push("rst_busy", O_BUSY, 0); push("rst_pkt", O_PKT, 0); push("rst_flit", O_FLIT, 0);
    push("rst_len", O_LEN, 0);   push("rst_err", O_ERR, 0);  push("rst_code", O_CODE, 0);
    push("rst_tog", O_TOG, 0);
    drain();

    // Normal packet on vch 1.
    flit(HEAD, 2'd1);
    push("nrm_busy_head", O_BUSY, 1); drain();
    for (int i = 0; i < 20; i++) flit(DATA, 2'd1);
    flit(TAIL, 2'd1);
    push("nrm_pkt", O_PKT, 1); push("nrm_flit", O_FLIT, 22); push("nrm_len", O_LEN, 20);
    push("nrm_err", O_ERR, 0); push("nrm_busy", O_BUSY, 0);
    drain();

    // DATA with no open packet, then a later error must not overwrite the code.
    do_reset();
    flit(DATA, 2'd0);
    push("nh_err", O_ERR, 1); push("nh_code", O_CODE, 1); push("nh_pkt", O_PKT, 0);
    push("nh_flit", O_FLIT, 1); push("nh_busy", O_BUSY, 0);
    drain();
    flit(HEAD, 2'd0); flit(HEAD, 2'd0);
    push("sticky_code", O_CODE, 1); push("sticky_err", O_ERR, 1); push("sticky_flit", O_FLIT, 3);
    drain();

    // Duplicate HEAD keeps the packet open.
    do_reset();
    flit(HEAD, 2'd2); flit(DATA, 2'd2); flit(HEAD, 2'd3);
    push("dup_code", O_CODE, 2); push("dup_busy", O_BUSY, 1); push("dup_flit", O_FLIT, 3);
    drain();
    flit(TAIL, 2'd3);
    push("dup_restart_pkt", O_PKT, 1); push("dup_restart_len", O_LEN, 0);
    drain();

    // MAXLEN DATA flits fit; one more overflows.
    do_reset();
    flit(HEAD, 2'd0);
    for (int i = 0; i < 32; i++) flit(DATA, 2'd0);
    push("ovl_pre_err", O_ERR, 0); push("ovl_pre_busy", O_BUSY, 1);
    drain();
    flit(DATA, 2'd0);
    push("ovl_code", O_CODE, 3); push("ovl_busy", O_BUSY, 0); push("ovl_pkt", O_PKT, 0);
    push("ovl_flit", O_FLIT, 34);
    drain();

    // VC mismatch on DATA and on TAIL.
    do_reset();
    flit(HEAD, 2'd0); flit(DATA, 2'd2);
    push("vch_code", O_CODE, 4); push("vch_busy", O_BUSY, 0);
    drain();
    do_reset();
    flit(HEAD, 2'd1); flit(TAIL, 2'd3);
    push("vcht_code", O_CODE, 4); push("vcht_pkt", O_PKT, 0); push("vcht_flit", O_FLIT, 2);
    drain();

    // Toggle counting: 0 then all-ones with ivalid low.
    do_reset();
    idata = '0; step();
    push("tog_zero", O_TOG, 0); push("tog_idle_flit", O_FLIT, 0);
    drain();
    idata = '1; step();
`ifdef TOGGLE_CNT_EN
    push("tog_66", O_TOG, 66);
`else
    push("tog_off", O_TOG, 0);
`endif
    push("tog_noacc_flit", O_FLIT, 0);
    drain();

    // clr alongside a HEAD: counters cleared, FSM still opens the packet.
    clr = 1'b1;
    flit(HEAD, 2'd1);
    clr = 1'b0;
    push("clr_busy", O_BUSY, 1); push("clr_flit", O_FLIT, 0); push("clr_pkt", O_PKT, 0);
    push("clr_tog", O_TOG, 0);   push("clr_err", O_ERR, 0);
    drain();
    flit(TAIL, 2'd1);
    push("clr_after_pkt", O_PKT, 1); push("clr_after_flit", O_FLIT, 1); push("clr_after_len", O_LEN, 0);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/flit_sink.md
FLIT_SINK -- requirements
Module: flit_sink

Interface
REQ-001 Parameter MAXLEN, 32, maximum DATA flits per packet.
REQ-002 Parameter CNTW, 16, width of the packet and flit counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_  input  1  reset, synchronous, active-low.
REQ-005 idata  input  66  flit; [65:64] type (00 NONE, 01 HEAD, 10 TAIL, 11 DATA), [63:0] payload.
REQ-006 ivalid  input  1  flit on idata/ivch is valid this cycle.
REQ-007 ivch  input  2  virtual channel of the flit.
REQ-008 clr  input  1  synchronous clear of counters and error state.
REQ-009 busy  output  1  high while a packet is open (state BODY).
REQ-010 pkt_cnt  output  CNTW  completed packets (HEAD..TAIL), saturating.
REQ-011 flit_cnt  output  CNTW  accepted flits (ivalid=1, type != NONE), saturating.
REQ-012 last_len  output  8  DATA-flit count of the last completed packet.
REQ-013 err  output  1  sticky error flag.
REQ-014 err_code  output  3  first error: 000 none, 001 NO_HEAD, 010 DUP_HEAD, 011 OVERLEN, 100 VCH.
REQ-015 tog_cnt  output  32  idata bit-toggle count (see Configuration).

Function
REQ-016 A flit is accepted only when ivalid=1 and type != NONE; in every other case the FSM and counters do not change.
REQ-017 FSM states: IDLE and BODY; all outputs are registered and reflect a flit one cycle after its sampling edge.
REQ-018 IDLE + HEAD -> BODY; capture ivch into vch_r; clear len.
REQ-019 IDLE + DATA or TAIL -> stay IDLE; raise error NO_HEAD.
REQ-020 BODY + DATA with len < MAXLEN and ivch == vch_r -> len+1.
REQ-021 BODY + DATA with len == MAXLEN -> raise OVERLEN; go to IDLE; do not count the packet.
REQ-022 BODY + TAIL with ivch == vch_r -> pkt_cnt+1; last_len = len; go to IDLE.
REQ-023 BODY + HEAD -> raise DUP_HEAD; drop the open packet; restart BODY with len=0 and vch_r=ivch.
REQ-024 BODY + DATA or TAIL with ivch != vch_r -> raise VCH; go to IDLE; do not count the packet.
REQ-025 Every accepted flit increments flit_cnt, including flits that raise an error.
REQ-026 pkt_cnt and flit_cnt saturate at all-ones with no wrap; len saturates at MAXLEN.
REQ-027 err stays high once set; err_code holds the first error until clr or reset, and later errors are ignored.
REQ-028 clr=1 zeroes pkt_cnt, flit_cnt, last_len, err, err_code and tog_cnt, and clear wins over a simultaneous increment.
REQ-029 clr=1 does not change the FSM state; a flit accepted in the same cycle still advances the FSM but is not counted.
REQ-030 busy = (state == BODY).

Reset
REQ-031 When rst_=0 at a rising edge: state=IDLE, len=0, vch_r=0, all outputs 0, and the internal idata sample register is 0.
REQ-032 Reset asserted mid-packet abandons the packet with no error; the first flit after reset is evaluated from IDLE.
REQ-033 Reset takes priority over clr and over any incoming flit.

Configuration
REQ-034 Macro TOGGLE_CNT_EN defined: each cycle, regardless of ivalid, tog_cnt increases by the Hamming distance between the current idata and the idata registered on the previous cycle, and saturates at 2^32-1.
REQ-035 Macro TOGGLE_CNT_EN undefined: the tog_cnt port remains, is tied to 0, and no toggle logic or sample register is synthesized.

Verification
REQ-036 Reset: rst_=0 for 2 cycles with random idata/ivalid -> all outputs 0, busy=0.
REQ-037 Normal packet: HEAD, 20 DATA, TAIL on vch 1, back-to-back -> pkt_cnt=1, flit_cnt=22, last_len=20, err=0; busy=0 one cycle after TAIL.
REQ-038 Framing errors, checked separately:
- DATA from IDLE -> err=1, err_code=001, pkt_cnt=0, flit_cnt=1.
- HEAD, DATA, HEAD -> err_code=010, busy=1.
REQ-039 Length and VC errors (MAXLEN=32), checked separately:
- HEAD plus 33 DATA -> err_code=011 after the 33rd DATA, busy=0.
- HEAD on vch 0 then DATA on vch 2 -> err_code=100.
REQ-040 Toggle counting:
- TOGGLE_CNT_EN defined: idata 0 then all-ones -> tog_cnt increases by 66.
- TOGGLE_CNT_EN defined: clr in the same cycle as a flit -> all counters 0 and the FSM still advances.
- TOGGLE_CNT_EN undefined: tog_cnt stays 0.
